// File: rtl/logic_avalon_mm_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS Avalon-MM masters share one
// Avalon-MM slave. Only one single-beat transaction is in flight at a time.
//
// Ports
//   aclk, areset_n            clock, asynchronous active-low reset
//   m_read/m_write            per-master requests
//   m_address/m_writedata/m_byteenable
//                             per-master command fields, master i at slice i
//   m_waitrequest             per-master stall; only the owner in CMD sees the
//                             slave's waitrequest, everyone else is held off
//   m_readdatavalid/m_writeresponsevalid
//                             per-master completion strobes, owner only
//   m_readdata/m_response     slave response broadcast, qualified by strobes
//   s_*                       shared-slave command and response
//   grant                     one-hot current owner, zero while idle
module logic_avalon_mm_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_BYTES     = 8,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WRITE_RESPONSE = 1
) (
  input  logic                                 aclk,
  input  logic                                 areset_n,
  input  logic [NUM_MASTERS-1:0]               m_read,
  input  logic [NUM_MASTERS-1:0]               m_write,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_BYTES*8-1:0]  m_writedata,
  input  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_byteenable,
  output logic [NUM_MASTERS-1:0]               m_waitrequest,
  output logic [NUM_MASTERS-1:0]               m_readdatavalid,
  output logic [NUM_MASTERS-1:0]               m_writeresponsevalid,
  output logic [DATA_BYTES*8-1:0]              m_readdata,
  output logic [1:0]                           m_response,
  output logic                                 s_read,
  output logic                                 s_write,
  output logic [ADDRESS_WIDTH-1:0]             s_address,
  output logic [DATA_BYTES*8-1:0]              s_writedata,
  output logic [DATA_BYTES-1:0]                s_byteenable,
  input  logic                                 s_waitrequest,
  input  logic                                 s_readdatavalid,
  input  logic                                 s_writeresponsevalid,
  input  logic [DATA_BYTES*8-1:0]              s_readdata,
  input  logic [1:0]                           s_response,
  output logic [NUM_MASTERS-1:0]               grant
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int DW    = DATA_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;       // index of the granted master
  logic [IDX_W-1:0]   last_grant;  // owner of the last completed transaction
  logic               txn_read;    // accepted command was a read

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       rr_cand;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_found;
  logic                   g_read;
  logic                   g_write;
  logic                   accept;
  logic                   done;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = (32'(base) + off) % 32'(NUM_MASTERS);
    return sum[IDX_W-1:0];
  endfunction

  assign req = m_read | m_write;

  // Search starts one past the previous owner so every requester is served
  // within NUM_MASTERS transactions.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      rr_cand = rr_index(last_grant, i);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign g_read  = m_read[owner];
  assign g_write = m_write[owner];

  // Command path is combinational from the owner's inputs; a simultaneous
  // read and write is presented as a read only.
  assign s_read       = (state == ST_CMD) && g_read;
  assign s_write      = (state == ST_CMD) && g_write && !g_read;
  assign s_address    = m_address[owner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign s_writedata  = m_writedata[owner*DW +: DW];
  assign s_byteenable = m_byteenable[owner*DATA_BYTES +: DATA_BYTES];

  assign m_readdata = s_readdata;
  assign m_response = s_response;

  assign accept = (s_read || s_write) && !s_waitrequest;
  assign done   = txn_read ? s_readdatavalid : s_writeresponsevalid;

  always_comb begin
    m_waitrequest        = '1;
    m_readdatavalid      = '0;
    m_writeresponsevalid = '0;
    if (state == ST_CMD) begin
      m_waitrequest[owner] = s_waitrequest;
    end
    // Slave strobes outside RESP (stale or spurious) are never forwarded.
    if (state == ST_RESP) begin
      if (txn_read) m_readdatavalid[owner]      = s_readdatavalid;
      else          m_writeresponsevalid[owner] = s_writeresponsevalid;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      state      <= ST_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      txn_read   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rr_found) begin
            owner <= rr_idx;
            grant <= NUM_MASTERS'(1) << rr_idx;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!g_read && !g_write) begin
            // Owner withdrew before acceptance: nothing reached the slave,
            // so the round-robin pointer is left where it was.
            state <= ST_IDLE;
            grant <= '0;
          end else if (accept) begin
            txn_read <= g_read;
            if (!g_read && WRITE_RESPONSE == 0) begin
              state      <= ST_IDLE;
              grant      <= '0;
              last_grant <= owner;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (done) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= owner;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_avalon_mm_arbiter.sv
// Bench for logic_avalon_mm_arbiter: two instances share all stimulus, one
// with WRITE_RESPONSE=0 (index 0) and one with WRITE_RESPONSE=1 (index 1).
// A transaction-level model predicts every output on each falling edge;
// directed scenarios add hand-computed expectations.
module tb_logic_avalon_mm_arbiter;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int AW = 16;
  localparam int DW = DB * 8;

  logic              aclk;
  logic              areset_n;
  logic [N-1:0]      m_read;
  logic [N-1:0]      m_write;
  logic [N*AW-1:0]   m_address;
  logic [N*DW-1:0]   m_writedata;
  logic [N*DB-1:0]   m_byteenable;
  logic              s_waitrequest;
  logic              s_readdatavalid;
  logic              s_writeresponsevalid;
  logic [DW-1:0]     s_readdata;
  logic [1:0]        s_response;

  logic [N-1:0]  o_wait   [2];
  logic [N-1:0]  o_rdv    [2];
  logic [N-1:0]  o_wrv    [2];
  logic [N-1:0]  o_grant  [2];
  logic [DW-1:0] o_rdata  [2];
  logic [1:0]    o_resp   [2];
  logic          o_sread  [2];
  logic          o_swrite [2];
  logic [AW-1:0] o_saddr  [2];
  logic [DW-1:0] o_swdata [2];
  logic [DB-1:0] o_sbe    [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic_avalon_mm_arbiter #(
    .NUM_MASTERS(N), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW), .WRITE_RESPONSE(0)
  ) dut_wr0 (
    .aclk(aclk), .areset_n(areset_n),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(o_wait[0]), .m_readdatavalid(o_rdv[0]),
    .m_writeresponsevalid(o_wrv[0]), .m_readdata(o_rdata[0]),
    .m_response(o_resp[0]), .s_read(o_sread[0]), .s_write(o_swrite[0]),
    .s_address(o_saddr[0]), .s_writedata(o_swdata[0]), .s_byteenable(o_sbe[0]),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_readdata(s_readdata),
    .s_response(s_response), .grant(o_grant[0])
  );

  logic_avalon_mm_arbiter #(
    .NUM_MASTERS(N), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW), .WRITE_RESPONSE(1)
  ) dut_wr1 (
    .aclk(aclk), .areset_n(areset_n),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(o_wait[1]), .m_readdatavalid(o_rdv[1]),
    .m_writeresponsevalid(o_wrv[1]), .m_readdata(o_rdata[1]),
    .m_response(o_resp[1]), .s_read(o_sread[1]), .s_write(o_swrite[1]),
    .s_address(o_saddr[1]), .s_writedata(o_swdata[1]), .s_byteenable(o_sbe[1]),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_readdata(s_readdata),
    .s_response(s_response), .grant(o_grant[1])
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner = -1 means no master holds the slave; acc = command already taken.
  int md_owner [2] = '{-1, -1};
  int md_last  [2] = '{N - 1, N - 1};
  bit md_acc   [2] = '{1'b0, 1'b0};
  bit md_kread [2] = '{1'b0, 1'b0};

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int d = 0; d < 2; d++) begin
        md_owner[d] <= -1;
        md_last[d]  <= N - 1;
        md_acc[d]   <= 1'b0;
        md_kread[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (md_owner[d] < 0) begin
          if (rr_pick(md_last[d], m_read | m_write) >= 0) begin
            md_owner[d] <= rr_pick(md_last[d], m_read | m_write);
            md_acc[d]   <= 1'b0;
          end
        end else if (!md_acc[d]) begin
          if (!m_read[md_owner[d]] && !m_write[md_owner[d]]) begin
            md_owner[d] <= -1;
          end else if (!s_waitrequest) begin
            md_kread[d] <= m_read[md_owner[d]];
            if (!m_read[md_owner[d]] && d == 0) begin
              md_owner[d] <= -1;
              md_last[d]  <= md_owner[d];
            end else begin
              md_acc[d] <= 1'b1;
            end
          end
        end else if (md_kread[d] ? s_readdatavalid : s_writeresponsevalid) begin
          md_owner[d] <= -1;
          md_acc[d]   <= 1'b0;
          md_last[d]  <= md_owner[d];
        end
      end
    end
  end

  task automatic compare_dut(input int d);
    logic [N-1:0] e_grant, e_wait, e_rdv, e_wrv;
    logic e_sread, e_swrite;
    int o;
    o = md_owner[d];
    e_grant = '0; e_wait = '1; e_rdv = '0; e_wrv = '0;
    e_sread = 1'b0; e_swrite = 1'b0;
    if (o >= 0) begin
      e_grant[o] = 1'b1;
      if (!md_acc[d]) begin
        e_wait[o] = s_waitrequest;
        e_sread   = m_read[o];
        e_swrite  = m_write[o] && !m_read[o];
      end else if (md_kread[d]) begin
        e_rdv[o] = s_readdatavalid;
      end else begin
        e_wrv[o] = s_writeresponsevalid;
      end
    end
    check($sformatf("d%0d grant", d), 64'(o_grant[d]), 64'(e_grant));
    check($sformatf("d%0d m_waitrequest", d), 64'(o_wait[d]), 64'(e_wait));
    check($sformatf("d%0d m_readdatavalid", d), 64'(o_rdv[d]), 64'(e_rdv));
    check($sformatf("d%0d m_writeresponsevalid", d), 64'(o_wrv[d]), 64'(e_wrv));
    check($sformatf("d%0d s_read", d), 64'(o_sread[d]), 64'(e_sread));
    check($sformatf("d%0d s_write", d), 64'(o_swrite[d]), 64'(e_swrite));
    check($sformatf("d%0d m_readdata", d), 64'(o_rdata[d]), 64'(s_readdata));
    check($sformatf("d%0d m_response", d), 64'(o_resp[d]), 64'(s_response));
    if (e_sread || e_swrite) begin
      check($sformatf("d%0d s_address", d), 64'(o_saddr[d]), 64'(m_address[o*AW +: AW]));
      check($sformatf("d%0d s_writedata", d), 64'(o_swdata[d]), 64'(m_writedata[o*DW +: DW]));
      check($sformatf("d%0d s_byteenable", d), 64'(o_sbe[d]), 64'(m_byteenable[o*DB +: DB]));
    end
  endtask

  always @(negedge aclk) begin
    compare_dut(0);
    compare_dut(1);
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(negedge aclk);
      if (o_grant[0] == '0 && o_grant[1] == '0) idle = 1'b1;
    end
    check("idle_reached", 64'(idle), 64'd1);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq[$];
    int exp_seq[4] = '{0, 1, 0, 1};
    logic [N-1:0] prev;

    areset_n = 1'b0;
    m_read = '0; m_write = '0; m_address = '0; m_writedata = '0; m_byteenable = '0;
    s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_writeresponsevalid = 1'b0;
    s_readdata = '0; s_response = '0;

    // Reset values.
    repeat (2) @(negedge aclk);
    check("rst grant", 64'(o_grant[1]), 64'd0);
    check("rst waitrequest", 64'(o_wait[1]), 64'h7);
    check("rst s_read", 64'(o_sread[1]), 64'd0);

    // Single read from m0, two slave wait cycles, data 0xA5.
    tick();
    areset_n = 1'b1;
    m_read[0] = 1'b1;
    m_address[0*AW +: AW] = 16'h0010;
    @(negedge aclk);
    check("rd idle grant", 64'(o_grant[1]), 64'd0);
    tick();
    @(negedge aclk);
    check("rd grant", 64'(o_grant[1]), 64'h1);
    check("rd s_read", 64'(o_sread[1]), 64'd1);
    check("rd s_address", 64'(o_saddr[1]), 64'h10);
    check("rd wait held", 64'(o_wait[1]), 64'h7);
    tick();
    tick();
    s_waitrequest = 1'b0;
    @(negedge aclk);
    check("rd wait low", 64'(o_wait[1]), 64'h6);
    tick();
    m_read[0] = 1'b0;
    s_waitrequest = 1'b1;
    @(negedge aclk);
    check("rd resp wait", 64'(o_wait[1]), 64'h7);
    tick();
    tick();
    s_readdatavalid = 1'b1;
    s_readdata = 32'hA5;
    @(negedge aclk);
    check("rd rdv", 64'(o_rdv[1]), 64'h1);
    check("rd rdv wr0", 64'(o_rdv[0]), 64'h1);
    check("rd readdata", 64'(o_rdata[1]), 64'hA5);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge aclk);
    check("rd back idle", 64'(o_grant[1]), 64'd0);

    // Reset, then m0 and m1 request back to back: grants alternate.
    tick();
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    m_read = 3'b011;
    s_waitrequest = 1'b0;
    s_readdatavalid = 1'b1;
    prev = '0;
    for (int c = 0; c < 30 && seq.size() < 4; c++) begin
      @(negedge aclk);
      if (o_grant[1] != '0 && prev == '0) seq.push_back(onehot_idx(o_grant[1]));
      prev = o_grant[1];
    end
    check("rr count", 64'(seq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) check($sformatf("rr grant %0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    end
    tick();
    m_read = '0;
    wait_idle();

    // Spurious readdatavalid in IDLE; m0 read+write together -> read only.
    tick();
    m_read[0] = 1'b1;
    m_write[0] = 1'b1;
    s_waitrequest = 1'b1;
    @(negedge aclk);
    check("spur rdv idle", 64'(o_rdv[1]), 64'd0);
    tick();
    @(negedge aclk);
    check("rw grant", 64'(o_grant[1]), 64'h1);
    check("rw s_read", 64'(o_sread[1]), 64'd1);
    check("rw s_write", 64'(o_swrite[1]), 64'd0);
    check("spur rdv cmd", 64'(o_rdv[1]), 64'd0);
    // m0 withdraws before acceptance: abort, pointer unchanged.
    tick();
    m_read = '0;
    m_write = '0;
    s_readdatavalid = 1'b0;
    tick();
    m_read = 3'b011;
    @(negedge aclk);
    check("abort idle", 64'(o_grant[1]), 64'd0);
    tick();
    @(negedge aclk);
    check("abort keeps ptr", 64'(o_grant[1]), 64'h1);
    check("abort keeps ptr wr0", 64'(o_grant[0]), 64'h1);
    tick();
    m_read = '0;
    wait_idle();

    // m1 write 0xDEADBEEF / 0x0F, accepted at once, response 2'b10.
    tick();
    m_write[1] = 1'b1;
    m_address[1*AW +: AW] = 16'h0020;
    m_writedata[1*DW +: DW] = 32'hDEAD_BEEF;
    m_byteenable[1*DB +: DB] = 4'hF;
    s_waitrequest = 1'b0;
    tick();
    @(negedge aclk);
    check("wr grant", 64'(o_grant[0]), 64'h2);
    check("wr s_write", 64'(o_swrite[0]), 64'd1);
    check("wr s_writedata", 64'(o_swdata[0]), 64'hDEAD_BEEF);
    check("wr s_byteenable", 64'(o_sbe[0]), 64'hF);
    check("wr waitrequest", 64'(o_wait[0]), 64'h5);
    tick();
    m_write = '0;
    s_writeresponsevalid = 1'b1;
    s_response = 2'b10;
    @(negedge aclk);
    check("wr0 idle after accept", 64'(o_grant[0]), 64'd0);
    check("wr0 no wrv", 64'(o_wrv[0]), 64'd0);
    check("wr1 wrv", 64'(o_wrv[1]), 64'h2);
    check("wr1 response", 64'(o_resp[1]), 64'h2);
    tick();
    s_writeresponsevalid = 1'b0;
    s_response = 2'b00;
    wait_idle();

    // Reset during RESP, late readdatavalid dropped, m0 wins afterwards.
    tick();
    m_read[1] = 1'b1;
    tick();
    tick();
    m_read = '0;
    s_waitrequest = 1'b1;
    @(negedge aclk);
    check("rst mid resp grant", 64'(o_grant[1]), 64'h2);
    #1 areset_n = 1'b0;
    #1 check("rst mid abort", 64'(o_grant[1]), 64'd0);
    tick();
    areset_n = 1'b1;
    s_readdatavalid = 1'b1;
    s_readdata = 32'h5A;
    @(negedge aclk);
    check("late rdv dropped", 64'(o_rdv[1]), 64'd0);
    check("late rdv grant", 64'(o_grant[1]), 64'd0);
    tick();
    s_readdatavalid = 1'b0;
    m_read = 3'b011;
    tick();
    @(negedge aclk);
    check("post rst m0 first", 64'(o_grant[1]), 64'h1);
    tick();
    m_read = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_avalon_mm_arbiter.md
LOGIC_AVALON_MM_ARBITER -- requirements
Module: logic_avalon_mm_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting Avalon-MM masters (range 2..8).
REQ-002 SHALL have parameter DATA_BYTES, default 8, bytes per data word (power of 2, 1..128).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, address bits (1..64).
REQ-004 SHALL have parameter WRITE_RESPONSE, default 1; 1 = writes complete on s_writeresponsevalid, 0 = writes complete on command acceptance.
REQ-005 SHALL have aclk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have areset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have m_read  input  NUM_MASTERS  per-master read request.
REQ-008 SHALL have m_write  input  NUM_MASTERS  per-master write request.
REQ-009 SHALL have m_address  input  NUM_MASTERS*ADDRESS_WIDTH  per-master address, master i at slice i.
REQ-010 SHALL have m_writedata  input  NUM_MASTERS*DATA_BYTES*8  per-master write data.
REQ-011 SHALL have m_byteenable  input  NUM_MASTERS*DATA_BYTES  per-master byte enables.
REQ-012 SHALL have m_waitrequest  output  NUM_MASTERS  per-master stall.
REQ-013 SHALL have m_readdatavalid, m_writeresponsevalid  output  NUM_MASTERS each  per-master completion strobes.
REQ-014 SHALL have m_readdata  output  DATA_BYTES*8 and m_response  output  2, broadcast to all masters, qualified by strobes.
REQ-015 SHALL have s_read, s_write  output  1; s_address  output  ADDRESS_WIDTH; s_writedata  output  DATA_BYTES*8; s_byteenable  output  DATA_BYTES: shared-slave command.
REQ-016 SHALL have s_waitrequest, s_readdatavalid, s_writeresponsevalid  input  1; s_readdata  input  DATA_BYTES*8; s_response  input  2: shared-slave response.
REQ-017 SHALL have grant  output  NUM_MASTERS  one-hot current owner (zero in IDLE).

Function
REQ-018 SHALL implement FSM IDLE -> CMD -> RESP -> IDLE, one transaction outstanding, single-beat only (no bursts).
REQ-019 IDLE: if any m_read|m_write asserted, SHALL register grant by round-robin starting from index (last_grant+1) mod NUM_MASTERS, go to CMD next cycle.
REQ-020 CMD: SHALL drive s_* command combinationally from granted master's inputs; s_read/s_write only in CMD.
REQ-021 CMD: m_waitrequest[g] SHALL equal s_waitrequest; all other m_waitrequest bits SHALL be 1 at all times.
REQ-022 Command accepted when s_read|s_write and !s_waitrequest; SHALL go to RESP, except write with WRITE_RESPONSE=0 goes to IDLE.
REQ-023 RESP: m_readdatavalid[g] SHALL equal s_readdatavalid (read) and m_writeresponsevalid[g] SHALL equal s_writeresponsevalid (write); other bits 0; on strobe go to IDLE.
REQ-024 m_readdata/m_response SHALL pass s_readdata/s_response through with zero latency.
REQ-025 Granted master dropping its request in CMD before acceptance SHALL cause return to IDLE with no slave completion expected.
REQ-026 s_readdatavalid or s_writeresponsevalid outside RESP SHALL be ignored (not forwarded).
REQ-027 last_grant SHALL update only on transaction completion; minimum IDLE time between transactions is 1 cycle.
REQ-028 Simultaneous m_read and m_write from one master: read SHALL take precedence, write ignored for that grant.

Reset
REQ-029 On areset_n low: state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), s_read=s_write=0, m_waitrequest=all 1, m_readdatavalid=m_writeresponsevalid=0.
REQ-030 Reset mid-transaction SHALL abort immediately; a late slave response after reset release SHALL be dropped per REQ-026.

Verification
REQ-031 Single read, m0 addr 0x10, slave wait 2 cycles, readdatavalid 3 cycles later data 0xA5 -> s_address=0x10, m_waitrequest[0] low 1 cycle, m_readdatavalid[0]=1 with 0xA5, m_readdatavalid[1]=0.
REQ-032 m0 and m1 request continuously after reset -> grants alternate 0,1,0,1 across 4 transactions; m_waitrequest of non-owner stays 1.
REQ-033 WRITE_RESPONSE=0, m1 write 0xDEAD_BEEF byteenable 0x0F, s_waitrequest=0 -> accepted in CMD cycle, FSM back to IDLE next cycle, no writeresponsevalid forwarded.
REQ-034 WRITE_RESPONSE=1, write accepted, s_response=2'b10 with writeresponsevalid -> m_writeresponsevalid[g]=1, m_response=2'b10.
REQ-035 Assert areset_n low during RESP, release, then pulse s_readdatavalid -> all m_readdatavalid stay 0, grant=0, next request from m0 granted first.
REQ-036 Spurious s_readdatavalid in IDLE and m0 read+write simultaneously -> no strobe forwarded; s_read=1, s_write=0 for m0 grant.
